// File: rtl/toy_mem_req_ctrl.sv
// Request front end for a 1-cycle-latency single-port word memory.
// Define TOY_MEM_REQ_CTRL_WR_ACK_EN to make aligned writes return an ack.
module toy_mem_req_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_wr_en,
  input  logic [DATA_WIDTH-1:0] req_wr_data,
  input  logic [ID_WIDTH-1:0]   req_id,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ID_WIDTH-1:0]   rsp_id,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int OFS = $clog2(DATA_WIDTH / 8);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = DATA_WIDTH + ID_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK =
    ADDR_WIDTH'((64'd1 << OFS) - 64'd1);

  logic                accept;
  logic                misaligned;
  logic                pend_set;
  logic                pend_vld;
  logic                pend_err;
  logic                pend_is_rd;
  logic [ID_WIDTH-1:0] pend_id;
  logic                push;
  logic                pop;
  logic                full;
  logic [EW-1:0]       push_entry;
  logic [EW-1:0]       head;
  logic [EW-1:0]       fifo_q [RSP_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [CW:0]         used;

  assign misaligned = |(req_addr & LOW_MASK);

  // Credits cover both queued entries and the one still in the capture stage
  assign used    = {1'b0, count} + (CW+1)'(pend_vld);
  assign req_rdy = !rst && (used < (CW+1)'(RSP_DEPTH));
  assign accept  = req_vld && req_rdy;

  assign mem_en      = accept && !misaligned;
  assign mem_wr_en   = mem_en && req_wr_en;
  assign mem_addr    = accept ? (req_addr >> OFS) : '0;
  assign mem_wr_data = accept ? req_wr_data : '0;

`ifdef TOY_MEM_REQ_CTRL_WR_ACK_EN
  assign pend_set = accept;
`else
  assign pend_set = accept && (!req_wr_en || misaligned);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld <= 1'b0;
    end else begin
      pend_vld <= pend_set;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_id    <= req_id;
      pend_err   <= misaligned;
      pend_is_rd <= !req_wr_en;
    end
  end

  assign push       = pend_vld;
  assign push_entry = {(pend_is_rd && !pend_err) ? mem_rd_data : '0,
                       pend_id, pend_err};

  assign full    = (count == CW'(RSP_DEPTH));
  assign rsp_vld = !rst && (count != '0);
  assign pop     = rsp_vld && rsp_rdy;
  assign head    = fifo_q[rd_ptr];
  assign {rsp_data, rsp_id, rsp_err} = rsp_vld ? head : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_toy_mem_req_ctrl.sv
// Bench for toy_mem_req_ctrl: directed steps plus random traffic
// against a queue-based response model and a word memory model.
module tb_toy_mem_req_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_addr;
  logic          req_wr_en;
  logic [DW-1:0] req_wr_data;
  logic [IW-1:0] req_id;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_data;
  logic [IW-1:0] rsp_id;
  logic          rsp_err;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_en;
  logic [DW-1:0] mem_rd_data = '0;

  logic [DW-1:0] mem_array [256] = '{default: '0};

  toy_mem_req_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ID_WIDTH(IW), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_addr(req_addr), .req_wr_en(req_wr_en),
    .req_wr_data(req_wr_data), .req_id(req_id),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Single-port word memory with one cycle of read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) mem_array[mem_addr[7:0]] <= mem_wr_data;
      else           mem_rd_data <= mem_array[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic          s_acc;
  logic          s_pop;
  logic          s_rsp_vld;
  logic          s_req_rdy;

  task automatic check(input logic [63:0] obs, input logic [63:0] exp,
                       input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step_model();
    logic          mis;
    logic [AW-1:0] word;
    logic          exp_vld;
    exp_t          e;
    s_acc     = 1'b0;
    s_pop     = 1'b0;
    s_rsp_vld = rsp_vld;
    s_req_rdy = req_rdy;
    if (rst) begin
      check(64'(req_rdy), 64'd0, "rst_req_rdy");
      check(64'({rsp_vld, rsp_data, rsp_id, rsp_err}), 64'd0, "rst_rsp");
      check(64'({mem_en, mem_wr_en, mem_addr, mem_wr_data}), 64'd0,
            "rst_mem");
      q.delete();
    end else begin
      check(64'(req_rdy), 64'(q.size() < DEPTH), "req_rdy_credit");
      exp_vld = (q.size() != 0) && (q[0].cyc <= cyc - 2);
      check(64'(rsp_vld), 64'(exp_vld), "rsp_vld");
      if (rsp_vld && exp_vld) begin
        check(64'({rsp_data, rsp_id, rsp_err}),
              64'({q[0].data, q[0].id, q[0].err}), "rsp_payload");
        if (rsp_rdy) begin
          void'(q.pop_front());
          s_pop = 1'b1;
        end
      end
      s_acc = req_vld && req_rdy;
      mis   = (req_addr[1:0] != 2'b00);
      word  = req_addr / 4;
      if (s_acc) begin
        check(64'({mem_en, mem_wr_en}),
              64'({!mis, !mis && req_wr_en}), "mem_ctl");
        check(64'({mem_addr, mem_wr_data}),
              64'({word, req_wr_data}), "mem_addr_data");
        e.id  = req_id;
        e.cyc = cyc;
        e.err = mis;
        e.data = '0;
        if (mis) begin
          q.push_back(e);
        end else if (req_wr_en) begin
          ref_mem[word[7:0]] = req_wr_data;
`ifdef TOY_MEM_REQ_CTRL_WR_ACK_EN
          q.push_back(e);
`endif
        end else begin
          e.data = ref_mem[word[7:0]];
          q.push_back(e);
        end
      end else begin
        check(64'({mem_en, mem_wr_en, mem_addr, mem_wr_data}), 64'd0,
              "mem_idle");
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [AW-1:0] a,
                         input logic w, input logic [DW-1:0] d,
                         input logic [IW-1:0] id);
    req_vld = v;
    req_addr = a;
    req_wr_en = w;
    req_wr_data = d;
    req_id = id;
  endtask

  task automatic drain();
    set_req(1'b0, '0, 1'b0, '0, '0);
    rsp_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    check(64'(q.size()), 64'd0, "drain_empty");
  endtask

  initial begin
    int acc_cnt;
    int pops;
    int first_pop;
    int last_pop;
    int id;

    rst = 1'b1;
    rsp_rdy = 1'b1;
    set_req(1'b0, '0, 1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check(64'(s_req_rdy), 64'd1, "rdy_after_reset");

    // read of unwritten word, 2-edge latency
    set_req(1'b1, 32'h10, 1'b0, '0, 4'd3);
    tick();
    check(64'(s_acc), 64'd1, "rd0_accept");
    set_req(1'b0, '0, 1'b0, '0, '0);
    tick();
    check(64'(s_rsp_vld), 64'd0, "rd0_t1_no_rsp");
    tick();
    check(64'({s_rsp_vld, s_pop}), 64'd3, "rd0_t2_rsp");
    drain();

    // write then read same word next cycle
    set_req(1'b1, 32'h20, 1'b1, 32'hDEADBEEF, 4'd4);
    tick();
    set_req(1'b1, 32'h20, 1'b0, '0, 4'd5);
    tick();
    drain();

    // misaligned read and write
    set_req(1'b1, 32'h13, 1'b0, '0, 4'd7);
    tick();
    set_req(1'b1, 32'h22, 1'b1, 32'h12345678, 4'd8);
    tick();
    drain();

    // backpressure: 6 reads against 4 credits
    rsp_rdy = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 32'h40 + 32'(acc_cnt * 4), 1'b0, '0, IW'(acc_cnt));
      tick();
      if (s_acc) acc_cnt++;
    end
    check(64'(acc_cnt), 64'd4, "bp_accepted");
    check(64'(s_req_rdy), 64'd0, "bp_rdy_low");
    rsp_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (acc_cnt == 6) break;
      set_req(1'b1, 32'h40 + 32'(acc_cnt * 4), 1'b0, '0, IW'(acc_cnt));
      tick();
      if (s_acc) acc_cnt++;
    end
    check(64'(acc_cnt), 64'd6, "bp_all_accepted");
    drain();

    // reset with two reads in flight
    rsp_rdy = 1'b0;
    set_req(1'b1, 32'h24, 1'b0, '0, 4'd1);
    tick();
    set_req(1'b1, 32'h28, 1'b0, '0, 4'd2);
    tick();
    set_req(1'b0, '0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check(64'({s_req_rdy, s_rsp_vld}), 64'd2, "post_rst_idle");
    end
    drain();

    // streaming 16 reads
    acc_cnt = 0;
    pops = 0;
    first_pop = -1;
    last_pop = -1;
    for (int i = 0; i < 18; i++) begin
      set_req(i < 16, 32'(i * 4), 1'b0, '0, IW'(i));
      tick();
      if (s_acc) acc_cnt++;
      if (s_pop) begin
        pops++;
        if (first_pop < 0) first_pop = i;
        last_pop = i;
      end
    end
    check(64'(acc_cnt), 64'd16, "stream_accepts");
    check(64'(pops), 64'd16, "stream_pops");
    check(64'(first_pop), 64'd2, "stream_first");
    check(64'(last_pop), 64'd17, "stream_last");
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      id = int'($urandom_range(0, 15));
      set_req($urandom_range(0, 3) != 0,
              32'($urandom_range(0, 63) * 4) +
                (($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : 0),
              1'($urandom_range(0, 1)), $urandom, IW'(id));
      rsp_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
